// File: rtl/vga_timing_checker_if.sv
// VGA timing stream bundle: counters, sync/blank strobes and 12-bit pixel colour.
// The checker observes it through the in modport; a timing generator drives it through out.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_checker.sv
// Passive VGA timing monitor: locks onto the incoming raster, then flags any deviation
// from the configured counter/sync/blank timing and any colour data driven during blanking.
module vga_timing_checker #(
    parameter int HTOTAL      = 1056,
    parameter int HBLNK_START = 800,
    parameter int HSYNC_START = 840,
    parameter int HSYNC_END   = 968,
    parameter int VTOTAL      = 628,
    parameter int VBLNK_START = 600,
    parameter int VSYNC_START = 601,
    parameter int VSYNC_END   = 605
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        err_clr,
    output logic        locked,
    output logic        err_cnt,
    output logic        err_sync,
    output logic        err_blnk,
    output logic        err_rgb,
    output logic [7:0]  err_count,
    output logic [15:0] frame_count
);
    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [10:0] H_BLNK = 11'(HBLNK_START);
    localparam logic [10:0] H_SYNS = 11'(HSYNC_START);
    localparam logic [10:0] H_SYNE = 11'(HSYNC_END);
    localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
    localparam logic [10:0] V_BLNK = 11'(VBLNK_START);
    localparam logic [10:0] V_SYNS = 11'(VSYNC_START);
    localparam logic [10:0] V_SYNE = 11'(VSYNC_END);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_r;
    logic        locked_r;
    logic [10:0] exp_h_r;
    logic [10:0] exp_v_r;
    logic [15:0] frame_count_r;

    logic [10:0] smp_h_r;
    logic [10:0] smp_v_r;
    logic        smp_hs_r;
    logic        smp_vs_r;
    logic        smp_hb_r;
    logic        smp_vb_r;
    logic [11:0] smp_rgb_r;
    logic        smp_vld_r;

    logic        err_cnt_r;
    logic        err_sync_r;
    logic        err_blnk_r;
    logic        err_rgb_r;
    logic [7:0]  err_count_r;

    logic        exp_hb_s;
    logic        exp_vb_s;
    logic        exp_hs_s;
    logic        exp_vs_s;
    logic        mis_cnt_s;
    logic        mis_sync_s;
    logic        mis_blnk_s;
    logic        mis_rgb_s;
    logic        err_s;
    logic        wrap_s;
    logic        sync_hit_s;
    logic [10:0] nxt_h_s;
    logic [10:0] nxt_v_s;
    logic [7:0]  cnt_inc_s;

    // Expected raster strobes, mismatch detection and next expected position.
    always_comb begin
        exp_hb_s   = (exp_h_r >= H_BLNK);
        exp_vb_s   = (exp_v_r >= V_BLNK);
        exp_hs_s   = (exp_h_r >= H_SYNS) && (exp_h_r < H_SYNE);
        exp_vs_s   = (exp_v_r >= V_SYNS) && (exp_v_r < V_SYNE);
        mis_cnt_s  = (smp_h_r != exp_h_r) || (smp_v_r != exp_v_r);
        mis_sync_s = (smp_hs_r != exp_hs_s) || (smp_vs_r != exp_vs_s);
        mis_blnk_s = (smp_hb_r != exp_hb_s) || (smp_vb_r != exp_vb_s);
        mis_rgb_s  = (exp_hb_s || exp_vb_s) && (smp_rgb_r != 12'h000);
        wrap_s     = (exp_h_r == H_LAST) && (exp_v_r == V_LAST);
        sync_hit_s = smp_vld_r && (smp_h_r == 11'd0) && (smp_v_r == 11'd0);
        nxt_h_s    = exp_h_r + 11'd1;
        nxt_v_s    = exp_v_r;
        if (exp_h_r == H_LAST) begin
            nxt_h_s = 11'd0;
            if (exp_v_r == V_LAST) begin
                nxt_v_s = 11'd0;
            end else begin
                nxt_v_s = exp_v_r + 11'd1;
            end
        end else begin
            nxt_h_s = exp_h_r + 11'd1;
        end
        if (state_r == SEARCH) begin
            err_s = 1'b0;
        end else begin
            err_s = mis_cnt_s || mis_sync_s || mis_blnk_s || mis_rgb_s;
        end
        if (err_count_r == 8'hFF) begin
            cnt_inc_s = 8'hFF;
        end else begin
            cnt_inc_s = err_count_r + 8'd1;
        end
    end

    // Input sample registers; smp_vld_r stops the reset-time zero sample from looking like (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_h_r   <= 11'd0;
            smp_v_r   <= 11'd0;
            smp_hs_r  <= 1'b0;
            smp_vs_r  <= 1'b0;
            smp_hb_r  <= 1'b0;
            smp_vb_r  <= 1'b0;
            smp_rgb_r <= 12'h000;
            smp_vld_r <= 1'b0;
        end else begin
            smp_h_r   <= vga_in.hcount;
            smp_v_r   <= vga_in.vcount;
            smp_hs_r  <= vga_in.hsync;
            smp_vs_r  <= vga_in.vsync;
            smp_hb_r  <= vga_in.hblnk;
            smp_vb_r  <= vga_in.vblnk;
            smp_rgb_r <= vga_in.rgb;
            smp_vld_r <= 1'b1;
        end
    end

    // Lock FSM with expected-position tracker and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= SEARCH;
            locked_r      <= 1'b0;
            exp_h_r       <= 11'd0;
            exp_v_r       <= 11'd0;
            frame_count_r <= 16'd0;
        end else begin
            case (state_r)
                SEARCH: begin
                    locked_r <= 1'b0;
                    if (sync_hit_s) begin
                        state_r <= TRACK;
                        exp_h_r <= 11'd1;
                        exp_v_r <= 11'd0;
                    end else begin
                        state_r <= SEARCH;
                    end
                end
                TRACK, LOCKED: begin
                    if (err_s) begin
                        state_r  <= SEARCH;
                        locked_r <= 1'b0;
                    end else begin
                        exp_h_r <= nxt_h_s;
                        exp_v_r <= nxt_v_s;
                        if (wrap_s) begin
                            state_r       <= LOCKED;
                            locked_r      <= 1'b1;
                            frame_count_r <= frame_count_r + 16'd1;
                        end
                    end
                end
                default: begin
                    state_r  <= SEARCH;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags and saturating error counter; a new error outranks err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r   <= 1'b0;
            err_sync_r  <= 1'b0;
            err_blnk_r  <= 1'b0;
            err_rgb_r   <= 1'b0;
            err_count_r <= 8'd0;
        end else if (err_s) begin
            if (err_clr) begin
                err_cnt_r   <= mis_cnt_s;
                err_sync_r  <= mis_sync_s;
                err_blnk_r  <= mis_blnk_s;
                err_rgb_r   <= mis_rgb_s;
                err_count_r <= 8'd1;
            end else begin
                err_cnt_r   <= err_cnt_r  | mis_cnt_s;
                err_sync_r  <= err_sync_r | mis_sync_s;
                err_blnk_r  <= err_blnk_r | mis_blnk_s;
                err_rgb_r   <= err_rgb_r  | mis_rgb_s;
                err_count_r <= cnt_inc_s;
            end
        end else if (err_clr) begin
            err_cnt_r   <= 1'b0;
            err_sync_r  <= 1'b0;
            err_blnk_r  <= 1'b0;
            err_rgb_r   <= 1'b0;
            err_count_r <= 8'd0;
        end
    end

    assign locked      = locked_r;
    assign err_cnt     = err_cnt_r;
    assign err_sync    = err_sync_r;
    assign err_blnk    = err_blnk_r;
    assign err_rgb     = err_rgb_r;
    assign err_count   = err_count_r;
    assign frame_count = frame_count_r;
endmodule

// File: tb/tb_vga_timing_checker.sv
// Scoreboard bench for vga_timing_checker on a shrunken 16x8 raster so whole frames stay short.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares them.
module tb_vga_timing_checker;
    localparam int HT  = 16;
    localparam int HB  = 10;
    localparam int HSS = 12;
    localparam int HSE = 14;
    localparam int VT  = 8;
    localparam int VB  = 6;
    localparam int VSS = 6;
    localparam int VSE = 7;
    localparam int FR  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_cnt;
    logic        err_sync;
    logic        err_blnk;
    logic        err_rgb;
    logic [7:0]  err_count;
    logic [15:0] frame_count;

    vga_if vga();

    vga_timing_checker #(
        .HTOTAL(HT), .HBLNK_START(HB), .HSYNC_START(HSS), .HSYNC_END(HSE),
        .VTOTAL(VT), .VBLNK_START(VB), .VSYNC_START(VSS), .VSYNC_END(VSE)
    ) dut (
        .clk(clk), .rst(rst), .vga_in(vga), .err_clr(err_clr),
        .locked(locked), .err_cnt(err_cnt), .err_sync(err_sync), .err_blnk(err_blnk),
        .err_rgb(err_rgb), .err_count(err_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tgt;
        int          tag;
        logic        lk;
        logic [3:0]  fl;
        logic [7:0]  ec;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // fl = {err_cnt, err_sync, err_blnk, err_rgb}
    task automatic cmp(input int tag, input logic lk, input logic [3:0] fl,
                       input logic [7:0] ec, input logic [15:0] fc);
        total++;
        if ({locked, err_cnt, err_sync, err_blnk, err_rgb, err_count, frame_count} !== {lk, fl, ec, fc}) begin
            bad++;
            $display("FAIL chk%0d cyc=%0d: got locked=%0b flags=%b err_count=%0d frame_count=%0d, want locked=%0b flags=%b err_count=%0d frame_count=%0d",
                     tag, cyc, locked, {err_cnt, err_sync, err_blnk, err_rgb}, err_count, frame_count,
                     lk, fl, ec, fc);
        end
    endtask

    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            m = q.pop_front();
            if (m.tgt < cyc) begin
                total++;
                bad++;
                $display("FAIL chk%0d missed: due cyc=%0d, now cyc=%0d", m.tag, m.tgt, cyc);
            end else begin
                cmp(m.tag, m.lk, m.fl, m.ec, m.fc);
            end
        end
    end

    task automatic set_pix(input int h, input int v);
        vga.hcount = 11'(h);
        vga.vcount = 11'(v);
        vga.hblnk  = (h >= HB);
        vga.vblnk  = (v >= VB);
        vga.hsync  = (h >= HSS) && (h < HSE);
        vga.vsync  = (v >= VSS) && (v < VSE);
        vga.rgb    = ((h >= HB) || (v >= VB)) ? 12'h000 : 12'h5A5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result for the pixel currently on the bus appears after the second rising edge.
    task automatic expect_out(input int tag, input logic lk, input logic [3:0] fl,
                              input logic [7:0] ec, input logic [15:0] fc);
        q.push_back('{cyc + 2, tag, lk, fl, ec, fc});
    endtask

    // Drive linear raster positions [from, to); tag >= 0 checks the last one.
    task automatic seg(input int from, input int to, input int tag, input logic lk,
                       input logic [3:0] fl, input logic [7:0] ec, input logic [15:0] fc);
        for (int p = from; p < to; p++) begin
            set_pix(p % HT, p / HT);
            if (tag >= 0 && p == to - 1) expect_out(tag, lk, fl, ec, fc);
            tick();
        end
    endtask

    task automatic frame(input int tag, input logic lk_pre, input logic lk_end,
                         input logic [3:0] fl, input logic [7:0] ec,
                         input logic [15:0] fc_pre, input logic [15:0] fc_end);
        seg(0, FR - 1, tag, lk_pre, fl, ec, fc_pre);
        seg(FR - 1, FR, tag + 1, lk_end, fl, ec, fc_end);
    endtask

    initial begin
        set_pix(0, 0);
        #2;
        cmp(0, 1'b0, 4'b0000, 8'd0, 16'd0);
        tick();
        tick();
        rst = 1'b0;

        // Clean lock and a second clean frame
        frame(10, 1'b0, 1'b1, 4'b0000, 8'd0, 16'd0, 16'd1);
        frame(12, 1'b1, 1'b1, 4'b0000, 8'd0, 16'd1, 16'd2);

        // Dropped hsync pulse while locked, then relock over the next full frame
        seg(0, 2 * HT + 12, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        set_pix(12, 2);
        vga.hsync = 1'b0;
        expect_out(20, 1'b0, 4'b0100, 8'd1, 16'd2);
        tick();
        seg(2 * HT + 13, FR, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        frame(21, 1'b0, 1'b1, 4'b0100, 8'd1, 16'd2, 16'd3);

        // Clear, colour in blanking, clear again
        set_pix(0, 0);
        tick();
        set_pix(1, 0);
        err_clr = 1'b1;
        expect_out(23, 1'b1, 4'b0000, 8'd0, 16'd3);
        tick();
        err_clr = 1'b0;
        seg(2, 3 * HT + 13, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        set_pix(13, 3);
        vga.rgb = 12'hFFF;
        expect_out(24, 1'b0, 4'b0001, 8'd1, 16'd3);
        tick();
        seg(3 * HT + 14, 4 * HT, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        set_pix(0, 4);
        err_clr = 1'b1;
        expect_out(25, 1'b0, 4'b0000, 8'd0, 16'd3);
        tick();
        err_clr = 1'b0;
        seg(4 * HT + 1, FR, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        frame(26, 1'b0, 1'b1, 4'b0000, 8'd0, 16'd3, 16'd4);

        // Skipped hcount with a stale blank strobe: two mismatches, one count
        seg(0, HT + 10, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        set_pix(11, 1);
        vga.hblnk = 1'b0;
        expect_out(28, 1'b0, 4'b1010, 8'd1, 16'd4);
        tick();

        // Repeated resync/error pairs drive err_count into saturation
        for (int k = 1; k <= 300; k++) begin
            set_pix(0, 0);
            tick();
            set_pix(5, 0);
            if (k == 10)  expect_out(29, 1'b0, 4'b1010, 8'd11, 16'd4);
            if (k == 253) expect_out(30, 1'b0, 4'b1010, 8'd254, 16'd4);
            if (k == 254) expect_out(31, 1'b0, 4'b1010, 8'd255, 16'd4);
            if (k == 300) expect_out(32, 1'b0, 4'b1010, 8'd255, 16'd4);
            tick();
        end

        // err_clr on the same edge as a new error keeps only the new error
        set_pix(0, 0);
        tick();
        set_pix(5, 0);
        expect_out(33, 1'b0, 4'b1000, 8'd1, 16'd4);
        tick();
        set_pix(3, 3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        frame(34, 1'b0, 1'b1, 4'b1000, 8'd1, 16'd4, 16'd5);

        // Asynchronous reset mid-frame, release mid-line: nothing flagged before (0,0)
        seg(0, 3 * HT + 7, -1, 1'b0, 4'b0000, 8'd0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        cmp(36, 1'b0, 4'b0000, 8'd0, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        seg(4 * HT + 5, FR, 37, 1'b0, 4'b0000, 8'd0, 16'd0);
        frame(38, 1'b0, 1'b1, 4'b0000, 8'd0, 16'd0, 16'd1);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_checker.md
VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

Interface
REQ-001 SHALL have parameter HTOTAL, default 1056: pixels per line (hcount 0..HTOTAL-1).
REQ-002 SHALL have parameter HBLNK_START, default 800: first hblnk pixel; blanking runs to HTOTAL-1.
REQ-003 SHALL have parameters HSYNC_START/HSYNC_END, defaults 840/968: hsync active for HSYNC_START <= hcount < HSYNC_END.
REQ-004 SHALL have parameter VTOTAL, default 628: lines per frame (vcount 0..VTOTAL-1).
REQ-005 SHALL have parameter VBLNK_START, default 600: first vblnk line; blanking runs to VTOTAL-1.
REQ-006 SHALL have parameters VSYNC_START/VSYNC_END, defaults 601/605: vsync active for VSYNC_START <= vcount < VSYNC_END.
REQ-007 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port vga_in, vga_if.in modport, -: monitored stream (vcount, hcount, vsync, vblnk, hsync, hblnk, rgb).
REQ-010 SHALL have port err_clr, input, 1: synchronous clear of sticky flags and err_count.
REQ-011 SHALL have port locked, output, 1: one full error-free frame tracked.
REQ-012 SHALL have port err_cnt, output, 1: sticky flag, hcount/vcount mismatch.
REQ-013 SHALL have port err_sync, output, 1: sticky flag, hsync/vsync mismatch.
REQ-014 SHALL have port err_blnk, output, 1: sticky flag, hblnk/vblnk mismatch.
REQ-015 SHALL have port err_rgb, output, 1: sticky flag, rgb nonzero while hblnk|vblnk.
REQ-016 SHALL have port err_count, output, 8: total detected errors, saturating at 255.
REQ-017 SHALL have port frame_count, output, 16: completed locked frames, wraps 65535->0.

Function
REQ-018 SHALL register all vga_in fields every clk; every check uses the registered sample; result is visible on outputs one clk after the check edge (two edges after input presented).
REQ-019 SHALL implement FSM SEARCH, TRACK, LOCKED; locked=1 only in LOCKED.
REQ-020 SHALL, in SEARCH, perform no checks and go to TRACK when sample has hcount==0 and vcount==0, loading expected position (h=1, v=0).
REQ-021 SHALL, in TRACK/LOCKED, advance expected position each clk: h wraps HTOTAL-1->0 and increments v; v wraps VTOTAL-1->0.
REQ-022 SHALL, in TRACK/LOCKED, compare sample against expected: counters exact; hblnk/vblnk/hsync/vsync per REQ-002..006 from expected position; rgb==0 when expected hblnk|vblnk.
REQ-023 SHALL, on any mismatch, set each applicable sticky flag, increment err_count by exactly 1 per cycle regardless of mismatch count, and go to SEARCH.
REQ-024 SHALL go TRACK->LOCKED on the error-free cycle where the expected position wraps (HTOTAL-1,VTOTAL-1)->(0,0).
REQ-025 SHALL increment frame_count on each such wrap while in LOCKED, and on the TRACK->LOCKED transition.
REQ-026 SHALL, on err_clr, zero all four flags and err_count; FSM, locked and frame_count unaffected.
REQ-027 SHALL, when err_clr and a new error coincide, give error priority: resulting flags are only those of the new error and err_count=1.
REQ-028 SHALL hold err_count at 255 on further errors; flags remain set until err_clr or rst.
REQ-029 SHALL, in a cycle where a mismatch sample has hcount==0 and vcount==0, still go to SEARCH (not re-sync same cycle).

Reset
REQ-030 SHALL, on rst, immediately set FSM=SEARCH, locked=0, all flags=0, err_count=0, frame_count=0, expected position=(0,0), sample registers=0.
REQ-031 SHALL, on rst release mid-frame, stay in SEARCH until next (0,0) sample.

Verification
REQ-032 SHALL verify: reset, feed ideal 800x600 stream from (0,0) for 2 frames -> locked rises after first frame wrap, frame_count=2, all flags 0.
REQ-033 SHALL verify: locked, force hsync=0 at hcount=900 one cycle -> err_sync=1, err_count=1, locked=0, re-lock after next full frame.
REQ-034 SHALL verify: locked, rgb=12'hFFF at hcount=1000 -> err_rgb=1 only; then err_clr pulse -> flags 0, err_count 0, frame_count unchanged.
REQ-035 SHALL verify: skip one hcount value (799->801) -> err_cnt=1 and err_blnk=1, err_count increments by 1 only.
REQ-036 SHALL verify: 300 single-cycle errors with resync between -> err_count saturates at 255; err_clr coincident with error -> err_count=1.
REQ-037 SHALL verify: assert rst mid-frame while locked -> outputs zero asynchronously; after release, start mid-line -> no errors flagged until (0,0) seen.
